iact_skew_feeder: RTL and testbench

- Transmit side of the activation path into the systolic PE array.
- Accepts one activation vector per cycle over a valid/ready stream and drives each array row's iact input with a diagonal skew, so row r sees a given vector r cycles after row 0.
- After the last vector of a tile, pushes zeros until the skew wavefront has fully entered the array, then pulses done.
- Sits between the activation buffer and the west edge of the PE grid.

---
 rtl/iact_skew_feeder_if.sv | 52 +++++
 rtl/iact_skew_feeder.sv | 176 +++++++++++++++++
 tb/tb_iact_skew_feeder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iact_skew_feeder_if.sv
// iact_skew_feeder_if
// Bundles the activation stream, the skewed array-side outputs and the
// tile status of iact_skew_feeder into one interface.
// - master: the activation source / observer side.
// - slave:  the feeder itself.
// Optional build macro honoured by the feeder: IACT_FEED_STALL_EN. The stall
// input it adds is a plain module port, so this interface is the same in
// both builds.
interface iact_skew_feeder_if #(
  parameter int ROWS  = 4,
  parameter int DW    = 16,
  parameter int CNT_W = 16
);
  // Activation stream from the activation buffer.
  logic [ROWS*DW-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;

  // Skewed activations towards the west edge of the PE grid.
  logic [ROWS*DW-1:0] iact_out;
  logic [ROWS-1:0]    iact_vld;

  // Tile status.
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   beat_cnt;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  iact_out,
    input  iact_vld,
    input  busy,
    input  done,
    input  beat_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output iact_out,
    output iact_vld,
    output busy,
    output done,
    output beat_cnt
  );
endinterface

// File: rtl/iact_skew_feeder.sv
// iact_skew_feeder
// Transmit side of the activation path into the systolic PE array.
// - Accepts one activation vector per cycle (valid/ready).
// - Row r of the vector leaves through a chain of r+1 registers, so row r
//   sees a beat r cycles after row 0 (diagonal skew).
// - Cycles without an accept inject a zero bubble with vld=0.
// - After the last beat of a tile the feeder refuses input for ROWS-1
//   cycles while the wavefront drains into the array, then pulses done
//   in the cycle the bottom row presents the last beat.
// Optional build macro: IACT_FEED_STALL_EN adds a 'stall' input that freezes
// every register (array-wide clock-enable), forces in_ready low and defers
// a pending done pulse until the first non-stalled cycle.
module iact_skew_feeder #(
  parameter int ROWS  = 4,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef IACT_FEED_STALL_EN
  input  logic stall,
`endif
  iact_skew_feeder_if.slave bus
);

  // FSM encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  // Flush counter only ever holds ROWS-1 down to 0.
  localparam int              FC_W       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(ROWS - 1);

  // Control registers
  logic [1:0]       r_state;
  logic [FC_W-1:0]  r_flush_cnt;
  logic             r_done;
  logic [CNT_W-1:0] r_beat_cnt;

  // Next-state values
  logic [1:0]       w_state_next;
  logic [FC_W-1:0]  w_flush_next;
  logic             w_done_next;
  logic [CNT_W-1:0] w_cnt_next;

  // Handshake / enable
  logic w_stall;
  logic w_adv;
  logic w_ready;
  logic w_accept;
  logic w_can_take;

  // Flattened skew outputs; each row drives its own slice.
  wire [ROWS*DW-1:0] w_iact_out;
  wire [ROWS-1:0]    w_iact_vld;

`ifdef IACT_FEED_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // w_adv is the array-wide clock enable: nothing moves while stalled.
  assign w_adv      = ~w_stall;
  assign w_can_take = (r_state != S_FLUSH);
  assign w_ready    = w_can_take & w_adv;
  assign w_accept   = bus.in_valid & w_ready;

  // Next-state logic: tile sequencing, beat counting and drain countdown.
  always_comb begin
    w_state_next = r_state;
    w_flush_next = r_flush_cnt;
    w_done_next  = 1'b0;
    w_cnt_next   = r_beat_cnt;
    case (r_state)
      S_IDLE, S_STREAM: begin
        if (w_accept) begin
          // The first beat of a tile restarts the count; later beats
          // saturate rather than wrap so a huge tile never reads as small.
          if (r_state == S_IDLE) begin
            w_cnt_next = CNT_W'(1);
          end else if (&r_beat_cnt) begin
            w_cnt_next = r_beat_cnt;
          end else begin
            w_cnt_next = r_beat_cnt + CNT_W'(1);
          end

          if (bus.in_last) begin
            if (ROWS > 1) begin
              // Rows 1..ROWS-1 still hold the tail of the wavefront.
              w_state_next = S_FLUSH;
              w_flush_next = FLUSH_LOAD;
            end else begin
              // A single row has no skew: the beat is in the array now.
              w_state_next = S_IDLE;
              w_done_next  = 1'b1;
            end
          end else begin
            w_state_next = S_STREAM;
          end
        end
      end
      S_FLUSH: begin
        // Leave at the edge where the counter reaches zero; that edge is
        // the one that moves the last beat into the bottom row's output.
        if (r_flush_cnt <= FC_W'(1)) begin
          w_state_next = S_IDLE;
          w_flush_next = '0;
          w_done_next  = 1'b1;
        end else begin
          w_flush_next = r_flush_cnt - FC_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_flush_next = '0;
      end
    endcase
  end

  // Control state registers; a stall freezes them, so a pending done
  // stays in r_done until the stall is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
      r_beat_cnt  <= '0;
    end else if (w_adv) begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_next;
      r_done      <= w_done_next;
      r_beat_cnt  <= w_cnt_next;
    end
  end

  // One skew chain per row; row gi is gi+1 registers deep.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [DW-1:0] r_data [0:gi];
      logic          r_vld  [0:gi];

      // Shift the row's chain; stage 0 captures the accepted slice or a
      // zero bubble, so the array never sees stale data for a missing beat.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k <= gi; k++) begin
            r_data[k] <= '0;
            r_vld[k]  <= 1'b0;
          end
        end else if (w_adv) begin
          r_data[0] <= w_accept ? bus.in_data[gi*DW +: DW] : '0;
          r_vld[0]  <= w_accept;
          for (int k = 1; k <= gi; k++) begin
            r_data[k] <= r_data[k-1];
            r_vld[k]  <= r_vld[k-1];
          end
        end
      end

      assign w_iact_out[gi*DW +: DW] = r_data[gi];
      assign w_iact_vld[gi]          = r_vld[gi];
    end
  endgenerate

  // Outputs
  assign bus.in_ready = w_ready;
  assign bus.iact_out = w_iact_out;
  assign bus.iact_vld = w_iact_vld;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done & w_adv;
  assign bus.beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_iact_skew_feeder.sv
`timescale 1ns/1ps
// Scoreboard bench for iact_skew_feeder (ROWS=4, DW=16).
// Time is measured in "advancing edges" (clock edges not under stall). A beat
// accepted at advancing edge A must appear on row r when A+r edges have
// advanced; a tile whose last beat is accepted at A must pulse done once
// A+ROWS-1 edges have advanced, and the feeder refuses input in between.
module tb_iact_skew_feeder;
  localparam int ROWS  = 4;
  localparam int DW    = 16;
  localparam int CNT_W = 16;
  localparam int W     = ROWS * DW;

  logic clk = 1'b0;
  logic rst;
  logic tb_stall = 1'b0;

  always #5 clk = ~clk;

  iact_skew_feeder_if #(.ROWS(ROWS), .DW(DW), .CNT_W(CNT_W)) bus ();

  iact_skew_feeder #(.ROWS(ROWS), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef IACT_FEED_STALL_EN
    .stall (tb_stall),
`endif
    .bus   (bus)
  );

  typedef struct { int tag; logic [DW-1:0] data; } beat_t;
  typedef struct { int tag; int cnt; } done_t;

  beat_t q_row [ROWS][$];
  done_t q_done[$];

  int n_cmp = 0;
  int n_bad = 0;

  int  adv_cnt;
  bit  adv_seen;
  int  last_tag = -1000;
  int  tile_cnt = 0;
  bit  in_tile = 0;
  bit  mon_en = 0;
  bit  rand_stall_en = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (adv=%0d t=%0t)", name, act, exp, adv_cnt, $time);
    end
  endtask

  // Count advancing edges; reset restarts the time base.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      adv_cnt  <= 0;
      adv_seen <= 1'b0;
    end else begin
      adv_seen <= !tb_stall;
      if (!tb_stall) adv_cnt <= adv_cnt + 1;
    end
  end

  // Feeder refuses input for the ROWS-1 cycles after a last beat.
  function automatic bit exp_ready(input int a);
    return !(a >= last_tag && a <= last_tag + ROWS - 2);
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic bit stall_pick();
`ifdef IACT_FEED_STALL_EN
    return rand_stall_en && ($urandom_range(0, 5) == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle; record expectations if the model says it is accepted.
  task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                      input logic s, output bit acc);
    int tag;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    tb_stall     = s;
    acc = v && !s && exp_ready(adv_cnt);
    if (acc) begin
      tag = adv_cnt + 1;
      for (int r = 0; r < ROWS; r++)
        q_row[r].push_back('{tag: tag + r, data: d[r*DW +: DW]});
      tile_cnt = in_tile ? tile_cnt + 1 : 1;
      in_tile  = 1'b1;
      if (l) begin
        q_done.push_back('{tag: tag + ROWS - 1, cnt: tile_cnt});
        in_tile  = 1'b0;
        last_tag = tag;
      end
      $display("beat adv=%0d last=%0b data=%h tile_beat=%0d", tag, l, d, tile_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc) begin
      step(1'b1, d, l, stall_pick(), acc);
      tries++;
      if (!acc && tries > 40) begin
        check("accept_timeout", tries, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, rand_vec(), 1'(($urandom & 1)), 1'b0, acc);
  endtask

  function automatic logic [W-1:0] seq_vec(input int base);
    logic [W-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(base + r);
    return v;
  endfunction

  // Monitor: compare every DUT output against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (adv_seen) begin
        for (int r = 0; r < ROWS; r++) begin
          bit exp_v;
          while (q_row[r].size() != 0 && q_row[r][0].tag < adv_cnt) void'(q_row[r].pop_front());
          exp_v = (q_row[r].size() != 0) && (q_row[r][0].tag == adv_cnt);
          check($sformatf("row%0d_vld", r), bus.iact_vld[r], exp_v);
          if (exp_v) begin
            beat_t b;
            b = q_row[r].pop_front();
            check($sformatf("row%0d_data", r), bus.iact_out[r*DW +: DW], b.data);
          end else begin
            check($sformatf("row%0d_bubble_zero", r), bus.iact_out[r*DW +: DW], 0);
          end
        end
      end
      check("in_ready", bus.in_ready, !tb_stall && exp_ready(adv_cnt));
      if (tb_stall) begin
        check("done_held_in_stall", bus.done, 0);
      end else begin
        bit exp_d;
        while (q_done.size() != 0 && q_done[0].tag < adv_cnt) void'(q_done.pop_front());
        exp_d = (q_done.size() != 0) && (q_done[0].tag == adv_cnt);
        check("done", bus.done, exp_d);
        if (exp_d) begin
          done_t dn;
          dn = q_done.pop_front();
          check("beat_cnt_at_done", bus.beat_cnt, dn.cnt);
          check("busy_at_done", bus.busy, 0);
          $display("done adv=%0d beat_cnt=%0d", adv_cnt, bus.beat_cnt);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iact_out"}, bus.iact_out, 0);
    check({tag, "_iact_vld"}, bus.iact_vld, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_beat_cnt"}, bus.beat_cnt, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1);
    check("post_reset_busy", bus.busy, 0);
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Three-beat tile {1,2,3,4},{5,6,7,8},{9,10,11,12}
    send_beat(seq_vec(1), 1'b0);
    send_beat(seq_vec(5), 1'b0);
    send_beat(seq_vec(9), 1'b1);
    idle(ROWS + 2);

    // Bubble between two beats
    send_beat(rand_vec(), 1'b0);
    idle(1);
    send_beat(rand_vec(), 1'b1);
    idle(ROWS + 1);

    // Single-beat tile
    send_beat(rand_vec(), 1'b1);
    idle(ROWS + 1);

    // Back-to-back tiles: next beat offered throughout the drain
    send_beat(rand_vec(), 1'b1);
    send_beat(rand_vec(), 1'b0);
    send_beat(rand_vec(), 1'b1);
    idle(ROWS + 1);

    // Asynchronous reset in the middle of a drain
    send_beat(rand_vec(), 1'b0);
    send_beat(rand_vec(), 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    for (int r = 0; r < ROWS; r++) q_row[r].delete();
    q_done.delete();
    in_tile  = 1'b0;
    last_tag = -1000;
    bus.in_valid = 1'b0;
    $display("reset asserted mid-flush");
    release_reset();

`ifdef IACT_FEED_STALL_EN
    // Two-cycle stall in the middle of a stream
    send_beat(rand_vec(), 1'b0);
    step(1'b1, seq_vec(100), 1'b0, 1'b1, acc);
    check("in_ready_stalled", bus.in_ready, 0);
    step(1'b1, seq_vec(100), 1'b0, 1'b1, acc);
    send_beat(seq_vec(100), 1'b0);
    send_beat(rand_vec(), 1'b1);
    idle(ROWS + 2);
    rand_stall_en = 1'b1;
`endif

    // Randomized tiles with random bubbles and random back-to-back starts
    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_beat(rand_vec(), 1'(b == len - 1));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, ROWS + 2));
    end

    rand_stall_en = 1'b0;
    idle(ROWS + 4);
    for (int r = 0; r < ROWS; r++) check($sformatf("row%0d_queue_drained", r), q_row[r].size(), 0);
    check("done_queue_drained", q_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
